bpm_estimator: RTL and testbench
================================

# bpm_estimator

Converts a raw heartbeat pulse from the pulse-sensor front end into an 8-bit beats-per-minute value. It also generates the shared 10 Hz sample strobe. The block sits directly upstream of the heart-rate misapplication checker: its `tick_10hz` and `bpm_buffer` outputs drive that stage's inputs of the same names. It measures the inter-beat interval (IBI) in milliseconds, rejects implausible intervals, computes 60000/IBI with a serial divider, and holds the last valid result.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. Must be a multiple of 1000.
- `MIN_BPM`, default 30: slowest accepted rate. Maximum accepted IBI = 60000/MIN_BPM = 2000 ms.
- `MAX_BPM`, default 220: fastest accepted rate. Refractory IBI = 60000/MAX_BPM = 272 ms.
- `TIMEOUT_MS`, default 3000: loss-of-signal limit. Must be ≤ 4095.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `beat_raw`, in, 1: sensor comparator output, asynchronous level. A rising edge marks a beat.
- `tick_10hz`, out, 1: one-`clk` strobe every 100 ms.
- `bpm_buffer`, out, 8: last valid BPM value; 0 when no valid value exists.
- `bpm_valid`, out, 1: high while `bpm_buffer` holds a measured value.
- `beat_stb`, out, 1: one-`clk` strobe for each detected rising edge, before filtering.

## Operation
- Timebase:
  - A prescaler counts 0..CLK_HZ/1000−1 and emits `ms_tick`. When CLK_HZ = 1000, `ms_tick` is high every cycle.
  - A decade counter of `ms_tick` emits `tick_10hz` on every 100th `ms_tick`, in the same cycle.
- Edge detect: `beat_raw` passes through a 2-FF synchronizer, then a delay register. Rising edge → `beat_stb`.
- `ibi_ms`: 12-bit counter. Increments on `ms_tick`, saturates at 4095, and is cleared to 0 when a beat is accepted.
- FSM states: IDLE (no reference beat), TRACK (reference held), DIV (division running).
  - IDLE + `beat_stb` → clear `ibi_ms`, go to TRACK. No output change.
  - TRACK + `beat_stb` with `ibi_ms` < 272 → ignore the edge. `ibi_ms` keeps counting.
  - TRACK + `beat_stb` with `ibi_ms` > 2000 → clear `ibi_ms`, stay in TRACK. No output change.
  - TRACK + `beat_stb` with 272 ≤ `ibi_ms` ≤ 2000 → latch divisor = `ibi_ms`, clear `ibi_ms`, go to DIV.
  - DIV: restoring division of 16-bit dividend 60000 by 12-bit divisor, one quotient bit per cycle, 16 cycles, truncating. On done:
    - `bpm_buffer` ← quotient clamped to [MIN_BPM, MAX_BPM].
    - `bpm_valid` ← 1.
    - Return to TRACK.
  - `beat_stb` during DIV is ignored; the refractory rule makes this unreachable in legal use. `ibi_ms` keeps counting during DIV.
  - TRACK or DIV with `ibi_ms` reaching TIMEOUT_MS → `bpm_buffer` ← 0, `bpm_valid` ← 0, go to IDLE. Timeout takes priority over a coincident `beat_stb`, which is dropped. A division in flight is aborted.
- Reset (asserted at any time, including mid-DIV):
  - All counters cleared, FSM to IDLE.
  - Outputs: `tick_10hz` = 0, `bpm_buffer` = 0, `bpm_valid` = 0, `beat_stb` = 0.
  - A division in progress is discarded.

## Timing
- `beat_raw` rise → `beat_stb` high: 3 `clk` edges (2 synchronizer flops + edge register).
- Accepted `beat_stb` cycle → `bpm_buffer`/`bpm_valid` update: 17 cycles (1 load + 16 iterations), registered.
- `bpm_buffer` changes only on a divider-done cycle or a timeout. It is stable for any `tick_10hz` cycle except those two events.
- `tick_10hz` period is exactly 100 × CLK_HZ/1000 cycles. The first pulse occurs 100 ms after reset release.
- The first valid BPM requires two accepted beats after reset or after a timeout.

## Structure
- Package `hr_pkg` holds:
  - `MS_PER_MIN` = 60000.
  - `BPM_W` = 8, `IBI_W` = 12.
  - FSM state enum.
  - Derived refractory and max-IBI constant functions.
- Sub-module `bpm_serial_div`:
  - Ports: `clk`, `rst_n`, `start`, `abort`, `divisor[11:0]`, `busy`, `done`, `quotient[15:0]`.
  - Dividend fixed at 60000.
- The top level holds the prescaler, the 10 Hz counter, the synchronizer, the `ibi_ms` counter, the FSM and the clamp.

## Test plan
All scenarios use CLK_HZ = 10_000 (10 `clk` per ms).
- Reset → all outputs 0; `tick_10hz` pulses every 1000 cycles, first pulse at cycle 1000 after release.
- Beats every 750 ms → no update after the first beat; after the second, `bpm_buffer` = 80 and `bpm_valid` = 1, exactly 17 cycles after `beat_stb`. Value stays 80 on later beats.
- Beats at 0 ms, 150 ms, 750 ms → 150 ms edge ignored; `bpm_buffer` = 80 after the 750 ms beat.
- Established 80 BPM, then a gap of 2500 ms → no update, 80 held; next beat 1000 ms later → `bpm_buffer` = 60.
- Established 80 BPM, then silence → at `ibi_ms` = 3000, `bpm_buffer` = 0 and `bpm_valid` = 0; the next single beat produces no output.
- Beat interval 300 ms with `rst_n` pulsed low 5 cycles into DIV → outputs 0 immediately, no late update; FSM in IDLE.

Source files
------------

// File: rtl/hr_pkg.sv
// Shared constants, FSM state type and derived timing limits for the
// heart-rate front end.
package hr_pkg;

  localparam int MS_PER_MIN = 60000;
  localparam int BPM_W      = 8;
  localparam int IBI_W      = 12;
  localparam int DIV_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no reference beat yet
    ST_TRACK = 2'd1,  // reference beat held, measuring the interval
    ST_DIV   = 2'd2   // converting an accepted interval into BPM
  } state_e;

  // Shortest accepted inter-beat interval in ms (fastest rate).
  function automatic int refractory_ms(input int max_bpm);
    return MS_PER_MIN / max_bpm;
  endfunction

  // Longest accepted inter-beat interval in ms (slowest rate).
  function automatic int max_ibi_ms(input int min_bpm);
    return MS_PER_MIN / min_bpm;
  endfunction

endpackage

// File: rtl/bpm_serial_div.sv
// Restoring divider: 60000 / divisor, one quotient bit per clock.
// done and quotient are presented during the last iteration so the caller
// can register the result on the same edge that finishes the division.
module bpm_serial_div
  import hr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IBI_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(MS_PER_MIN);

  logic [IBI_W-1:0] div_q;
  logic [IBI_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [4:0]       cnt_q;
  logic             busy_q;
  logic [IBI_W:0]   rem_sh;
  logic             take;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[DIV_W-1]};
    take   = (rem_sh >= {1'b0, div_q});
    rem_d  = take ? IBI_W'(rem_sh - {1'b0, div_q}) : IBI_W'(rem_sh);
    quo_d  = {quo_q[DIV_W-2:0], take};
  end

  // Load on start, iterate while busy, drop everything on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start && !busy_q) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would chain the updates in one edge.
      div_q  <= divisor;
      rem_q  <= '0;
      quo_q  <= DIVIDEND;
      cnt_q  <= 5'd16;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) busy_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == 5'd1);
  assign quotient = quo_d;

endmodule

// File: rtl/bpm_estimator.sv
// Heartbeat pulse to BPM converter with shared 10 Hz strobe generation.
// Measures the inter-beat interval in ms, rejects implausible intervals,
// divides 60000 by the interval and holds the last valid result.
module bpm_estimator
  import hr_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_BPM    = 30,
  parameter int MAX_BPM    = 220,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_raw,
  output logic             tick_10hz,
  output logic [BPM_W-1:0] bpm_buffer,
  output logic             bpm_valid,
  output logic             beat_stb
);

  localparam int PRE_N = CLK_HZ / 1000;
  localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
  localparam logic [IBI_W-1:0] REFRACT  = IBI_W'(refractory_ms(MAX_BPM));
  localparam logic [IBI_W-1:0] MAX_IBI  = IBI_W'(max_ibi_ms(MIN_BPM));
  localparam logic [IBI_W-1:0] TIMEOUT  = IBI_W'(TIMEOUT_MS);
  localparam logic [DIV_W-1:0] Q_MIN    = DIV_W'(MIN_BPM);
  localparam logic [DIV_W-1:0] Q_MAX    = DIV_W'(MAX_BPM);

  logic [PRE_W-1:0] pre_q;
  logic [6:0]       dec_q;
  logic             ms_tick;
  logic [1:0]       sync_q;
  logic             dly_q, stb_q;
  logic [IBI_W-1:0] ibi_q, ibi_d;
  state_e           state_q;
  logic [BPM_W-1:0] bpm_q, bpm_clamped;
  logic             valid_q;
  logic             timeout_hit, accept, reject_long, first_beat;
  logic             div_start, div_abort, div_busy, div_done;
  logic [DIV_W-1:0] div_quo;

  assign ms_tick   = (pre_q == PRE_LAST);
  assign tick_10hz = ms_tick && (dec_q == 7'd99);

  // Millisecond prescaler and 100 ms decade counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      dec_q <= '0;
    end else begin
      pre_q <= ms_tick ? '0 : pre_q + 1'b1;
      if (ms_tick) dec_q <= (dec_q == 7'd99) ? 7'd0 : dec_q + 7'd1;
    end
  end

  // Two-flop synchronizer, delay register and registered rising-edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], beat_raw};
      dly_q  <= sync_q[1];
      stb_q  <= sync_q[1] & ~dly_q;
    end
  end

  // Beat classification, interval counter next state and result clamp.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    timeout_hit = 1'b0;
    accept      = 1'b0;
    reject_long = 1'b0;
    first_beat  = 1'b0;
    ibi_d       = ibi_q;
    bpm_clamped = BPM_W'(div_quo);

    timeout_hit = (state_q != ST_IDLE) && (ibi_q >= TIMEOUT);
    first_beat  = (state_q == ST_IDLE) && stb_q;
    if ((state_q == ST_TRACK) && stb_q && !timeout_hit) begin
      accept      = (ibi_q >= REFRACT) && (ibi_q <= MAX_IBI);
      reject_long = (ibi_q > MAX_IBI);
    end

    if (first_beat || accept || reject_long) ibi_d = '0;
    else if (ms_tick && (ibi_q != '1))       ibi_d = ibi_q + 1'b1;

    if (div_quo < Q_MIN)      bpm_clamped = BPM_W'(MIN_BPM);
    else if (div_quo > Q_MAX) bpm_clamped = BPM_W'(MAX_BPM);
  end

  assign div_start = accept && !div_busy;
  assign div_abort = timeout_hit && (state_q == ST_DIV);

  // Inter-beat interval counter in ms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ibi_q <= '0;
    else        ibi_q <= ibi_d;
  end

  // Beat tracking FSM with registered BPM result and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bpm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (first_beat) state_q <= ST_TRACK;
        end
        ST_TRACK: begin
          if (timeout_hit) begin
            state_q <= ST_IDLE;
            bpm_q   <= '0;
            valid_q <= 1'b0;
          end else if (accept) begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (timeout_hit) begin
            state_q <= ST_IDLE;
            bpm_q   <= '0;
            valid_q <= 1'b0;
          end else if (div_done) begin
            state_q <= ST_TRACK;
            bpm_q   <= bpm_clamped;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  bpm_serial_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .divisor  (ibi_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign bpm_buffer = bpm_q;
  assign bpm_valid  = valid_q;
  assign beat_stb   = stb_q;

endmodule

// File: tb/tb_bpm_estimator.sv
// Directed bench for bpm_estimator at CLK_HZ = 10_000 (10 clk per ms).
module tb_bpm_estimator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       beat_raw;
  logic       tick_10hz;
  logic [7:0] bpm_buffer;
  logic       bpm_valid;
  logic       beat_stb;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = 0;
  logic [8:0] prev_out = 9'd0;

  int pe = 0;
  int tick_bad = 0;
  int tick_seen = 0;
  int first_tick = 0;

  typedef struct {
    int         gap_ms;
    logic [7:0] bpm;
    logic       valid;
  } vec_t;

  vec_t vecs[5];

  bpm_estimator #(
    .CLK_HZ    (10_000),
    .MIN_BPM   (30),
    .MAX_BPM   (220),
    .TIMEOUT_MS(3000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_raw  (beat_raw),
    .tick_10hz (tick_10hz),
    .bpm_buffer(bpm_buffer),
    .bpm_valid (bpm_valid),
    .beat_stb  (beat_stb)
  );

  always #5 clk = ~clk;

  // Tick monitor: after n edges since reset release the strobe is high iff
  // n+1 is a multiple of 1000; always low while reset is held.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      pe = 0;
      if (tick_10hz !== 1'b0) tick_bad++;
    end else begin
      pe++;
      if (tick_10hz !== (((pe + 1) % 1000) == 0)) tick_bad++;
      if (tick_10hz === 1'b1) begin
        tick_seen++;
        if (first_tick == 0) first_tick = pe + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  // Raise beat_raw and wait (bounded) for the strobe; returns cycles taken.
  task automatic rise_and_find(input int gap_ms, input string name, output bit found);
    int lat;
    wait_until(last_rise + gap_ms * 10);
    beat_raw  = 1'b1;
    last_rise = cyc;
    found     = 1'b0;
    lat       = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      step(1);
      if (beat_stb === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check({name, "_stb_lat"}, lat, 3);
    beat_raw = 1'b0;
  endtask

  // One beat: output must hold for 16 cycles after the strobe and show the
  // expected value on the 17th.
  task automatic apply_beat(input int gap_ms, input logic [7:0] exp_bpm,
                            input logic exp_valid, input string name);
    bit found;
    rise_and_find(gap_ms, name, found);
    if (found) begin
      step(1);
      check({name, "_stb_width"}, beat_stb, 0);
      step(15);
      check({name, "_hold16"}, {bpm_valid, bpm_buffer}, prev_out);
      step(1);
      check({name, "_at17"}, {bpm_valid, bpm_buffer}, {exp_valid, exp_bpm});
    end
    prev_out = {exp_valid, exp_bpm};
  endtask

  initial begin
    bit found;

    vecs[0] = '{10,   8'd0,  1'b0};  // first beat: reference only
    vecs[1] = '{150,  8'd0,  1'b0};  // inside refractory window: ignored
    vecs[2] = '{600,  8'd80, 1'b1};  // 750 ms after reference -> 80
    vecs[3] = '{2500, 8'd80, 1'b1};  // too long: rejected, value held
    vecs[4] = '{1000, 8'd60, 1'b1};  // 1000 ms -> 60

    rst_n    = 1'b0;
    beat_raw = 1'b0;
    step(3);
    check("reset_bpm",   bpm_buffer, 0);
    check("reset_valid", bpm_valid,  0);
    check("reset_stb",   beat_stb,   0);
    check("reset_tick",  tick_10hz,  0);
    rst_n     = 1'b1;
    last_rise = cyc;

    for (int i = 0; i < 5; i++)
      apply_beat(vecs[i].gap_ms, vecs[i].bpm, vecs[i].valid, $sformatf("vec%0d", i));

    // Reset pulsed while a 300 ms interval is being divided.
    rise_and_find(300, "div_reset", found);
    step(6);
    check("pre_reset_out", {bpm_valid, bpm_buffer}, {1'b1, 8'd60});
    rst_n = 1'b0;
    #1;
    check("mid_reset_out",  {bpm_valid, bpm_buffer}, 0);
    check("mid_reset_stb",  beat_stb, 0);
    check("mid_reset_tick", tick_10hz, 0);
    step(3);
    rst_n     = 1'b1;
    last_rise = cyc;
    prev_out  = 9'd0;
    step(30);
    check("no_late_update", {bpm_valid, bpm_buffer}, 0);
    apply_beat(300, 8'd0,  1'b0, "idle_after_reset");
    apply_beat(750, 8'd80, 1'b1, "second_after_reset");

    // Silence after an established 80 BPM: loss of signal at 3000 ms.
    wait_until(last_rise + 29900);
    check("before_timeout", {bpm_valid, bpm_buffer}, {1'b1, 8'd80});
    wait_until(last_rise + 30100);
    check("after_timeout", {bpm_valid, bpm_buffer}, 0);
    prev_out = 9'd0;
    apply_beat(3020, 8'd0, 1'b0, "single_after_timeout");

    check("tick_bad_cycles", tick_bad, 0);
    check("tick_first_cycle", first_tick, 1000);
    check("tick_pulses_seen", (tick_seen > 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
